// File: rtl/manager_response_stage_pkg.sv
// Shared AHB response-path types and constants for the manager response stage.
// Holds the FSM state encoding, HTRANS codes and the request decode helper.
package manager_response_stage_pkg;

    typedef enum logic [1:0] {
        RS_IDLE = 2'd0,
        RS_HOLD = 2'd1,
        RS_DATA = 2'd2,
        RS_ERR  = 2'd3
    } respstate_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // IDLE and BUSY beats never open an address phase.
    function automatic logic is_request(input logic hsel, input logic [1:0] htrans);
        return hsel && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/manager_response_stage.sv
// Per-manager AHB response stage: stalls the manager while its address phase waits for
// GRANT, forwards the shared subordinate response in owned data phases, holds last read data.
module manager_response_stage
    import manager_response_stage_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 8
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [1:0]        HTRANS,
    input  logic              GRANT,
    input  logic              GRANTD,
    input  logic              HREADYS,
    input  logic              HRESPS,
    input  logic [DATA_W-1:0] HRDATAS,
    output logic              HREADYM,
    output logic              HRESPM,
    output logic [DATA_W-1:0] HRDATAM,
    output logic              Pending,
    output logic [CNT_W-1:0]  WaitCnt
);

    typedef struct packed {
        logic [DATA_W-1:0] hrdata;
        logic              hready;
        logic              hresp;
    } ahb_response_t;

    localparam logic [CNT_W-1:0] WAIT_MAX = {CNT_W{1'b1}};

    respstate_t        state_q, state_d;
    respstate_t        after_done;
    logic [DATA_W-1:0] hold_q;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic              req;
    logic              capture;
    ahb_response_t     resp;

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        req        = is_request(HSEL, HTRANS);
        after_done = req ? (GRANT ? RS_DATA : RS_HOLD) : RS_IDLE;
        state_d    = state_q;
        capture    = 1'b0;
        unique case (state_q)
            RS_IDLE: state_d = after_done;
            RS_HOLD: begin
                if (req && GRANT && HREADYS) state_d = RS_DATA;
                else if (!req)               state_d = RS_IDLE;
            end
            RS_DATA: begin
                if (GRANTD) begin
                    if (HREADYS && !HRESPS) begin
                        capture = 1'b1;
                        state_d = after_done;
                    end else if (!HREADYS && HRESPS) begin
                        state_d = RS_ERR;
                    end
                end
            end
            RS_ERR: begin
                // Second ERROR cycle completes like a normal data phase, without capture.
                if (HREADYS) state_d = after_done;
            end
            default: state_d = RS_IDLE;
        endcase
    end

    always_comb begin
        wait_d = wait_q;
        if (state_d == RS_HOLD && state_q != RS_HOLD) wait_d = '0;
        else if (state_q == RS_HOLD && wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;
    end

    always_comb begin
        resp.hrdata = hold_q;
        resp.hready = 1'b1;
        resp.hresp  = 1'b0;
        unique case (state_q)
            RS_HOLD: resp.hready = 1'b0;
            RS_DATA: begin
                if (GRANTD) begin
                    resp.hrdata = HRDATAS;
                    resp.hready = HREADYS;
                    resp.hresp  = HRESPS;
                end else begin
                    // Arbiter has not handed over the data phase yet; keep the manager stalled.
                    resp.hready = 1'b0;
                end
            end
            RS_ERR: begin
                resp.hrdata = HRDATAS;
                resp.hready = HREADYS;
                resp.hresp  = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= RS_IDLE;
            wait_q  <= '0;
            // NOTE: the read-data hold register is reset because HRDATAM must read zero after reset.
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (capture) hold_q <= HRDATAS;
        end
    end

    assign HREADYM = resp.hready;
    assign HRESPM  = resp.hresp;
    assign HRDATAM = resp.hrdata;
    assign Pending = (state_q == RS_HOLD);
    assign WaitCnt = wait_q;

endmodule

// File: tb/tb_manager_response_stage.sv
// Directed bench for manager_response_stage: a vector table for the main flow plus
// hand-written sequences for ERROR, asynchronous reset and wait-counter saturation.
module tb_manager_response_stage;

    localparam logic [1:0] T_ID = 2'b00;
    localparam logic [1:0] T_BS = 2'b01;
    localparam logic [1:0] T_NS = 2'b10;
    localparam logic [1:0] T_SQ = 2'b11;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [1:0]  HTRANS;
    logic        GRANT, GRANTD, HREADYS, HRESPS;
    logic [63:0] HRDATAS;
    logic        HREADYM, HRESPM, Pending;
    logic [63:0] HRDATAM;
    logic [7:0]  WaitCnt;
    logic        hreadym2, hrespm2, pending2;
    logic [63:0] hrdatam2;
    logic [1:0]  waitcnt2;

    int compared = 0;
    int mismatched = 0;

    always #5 HCLK = ~HCLK;

    manager_response_stage #(.DATA_W(64), .CNT_W(8)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS), .GRANT(GRANT),
        .GRANTD(GRANTD), .HREADYS(HREADYS), .HRESPS(HRESPS), .HRDATAS(HRDATAS),
        .HREADYM(HREADYM), .HRESPM(HRESPM), .HRDATAM(HRDATAM), .Pending(Pending),
        .WaitCnt(WaitCnt)
    );

    manager_response_stage #(.DATA_W(64), .CNT_W(2)) dut2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS), .GRANT(GRANT),
        .GRANTD(GRANTD), .HREADYS(HREADYS), .HRESPS(HRESPS), .HRDATAS(HRDATAS),
        .HREADYM(hreadym2), .HRESPM(hrespm2), .HRDATAM(hrdatam2), .Pending(pending2),
        .WaitCnt(waitcnt2)
    );

    typedef struct {
        logic        hsel;
        logic [1:0]  htrans;
        logic        grant, grantd, hreadys, hresps;
        logic [63:0] hrdatas;
        logic        e_hready, e_hresp;
        logic [63:0] e_hrdata;
        logic        e_pending;
        logic [7:0]  e_wait;
    } vec_t;

    function automatic vec_t mk(input logic hs, input logic [1:0] ht, input logic g,
                                input logic gd, input logic rs, input logic rp,
                                input logic [63:0] rd, input logic eh, input logic ep,
                                input logic [63:0] ed, input logic epd, input logic [7:0] ew);
        vec_t v;
        v.hsel = hs; v.htrans = ht; v.grant = g; v.grantd = gd;
        v.hreadys = rs; v.hresps = rp; v.hrdatas = rd;
        v.e_hready = eh; v.e_hresp = ep; v.e_hrdata = ed; v.e_pending = epd; v.e_wait = ew;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic hs, input logic [1:0] ht, input logic g, input logic gd,
                         input logic rs, input logic rp, input logic [63:0] rd);
        HSEL = hs; HTRANS = ht; GRANT = g; GRANTD = gd;
        HREADYS = rs; HRESPS = rp; HRDATAS = rd;
    endtask

    vec_t vecs[19];

    initial begin
        // Main flow: single read, held request (WaitCnt=3), arbiter lag, back-to-back, BUSY.
        vecs[0]  = mk(1, T_NS, 1, 0, 1, 0, 64'h11,   1, 0, 64'h0,  0, 0);
        vecs[1]  = mk(0, T_ID, 0, 1, 1, 0, 64'hA5,   1, 0, 64'hA5, 0, 0);
        vecs[2]  = mk(0, T_ID, 0, 0, 1, 0, 64'h77,   1, 0, 64'hA5, 0, 0);
        vecs[3]  = mk(1, T_NS, 0, 0, 1, 0, 64'h77,   1, 0, 64'hA5, 0, 0);
        vecs[4]  = mk(1, T_NS, 0, 0, 1, 0, 64'h77,   0, 0, 64'hA5, 1, 0);
        vecs[5]  = mk(1, T_NS, 0, 0, 1, 0, 64'h77,   0, 0, 64'hA5, 1, 1);
        vecs[6]  = mk(1, T_NS, 1, 0, 1, 0, 64'h77,   0, 0, 64'hA5, 1, 2);
        vecs[7]  = mk(0, T_ID, 0, 1, 0, 0, 64'h33,   0, 0, 64'h33, 0, 3);
        vecs[8]  = mk(0, T_ID, 0, 0, 1, 1, 64'h44,   0, 0, 64'hA5, 0, 3);
        vecs[9]  = mk(1, T_SQ, 1, 1, 1, 0, 64'h0123_4567_89AB_CD5A, 1, 0, 64'h0123_4567_89AB_CD5A, 0, 3);
        vecs[10] = mk(1, T_SQ, 1, 1, 1, 0, 64'hFEDC_0000_0000_0061, 1, 0, 64'hFEDC_0000_0000_0061, 0, 3);
        vecs[11] = mk(1, T_BS, 1, 1, 1, 0, 64'h62,   1, 0, 64'h62, 0, 3);
        vecs[12] = mk(1, T_BS, 1, 0, 1, 0, 64'h70,   1, 0, 64'h62, 0, 3);
        vecs[13] = mk(0, T_NS, 1, 0, 1, 0, 64'h70,   1, 0, 64'h62, 0, 3);
        vecs[14] = mk(1, T_NS, 0, 0, 1, 0, 64'h70,   1, 0, 64'h62, 0, 3);
        vecs[15] = mk(1, T_NS, 1, 0, 0, 0, 64'h70,   0, 0, 64'h62, 1, 0);
        vecs[16] = mk(1, T_NS, 1, 0, 1, 0, 64'h70,   0, 0, 64'h62, 1, 1);
        vecs[17] = mk(0, T_ID, 0, 1, 1, 0, 64'h99,   1, 0, 64'h99, 0, 2);
        vecs[18] = mk(0, T_ID, 0, 0, 1, 0, 64'h70,   1, 0, 64'h99, 0, 2);

        HRESETn = 1'b0;
        drive(0, T_ID, 0, 0, 1, 0, 64'h0);
        repeat (2) @(negedge HCLK);
        check("reset hreadym", 64'(HREADYM), 64'd1);
        check("reset hrespm",  64'(HRESPM),  64'd0);
        check("reset hrdatam", HRDATAM,      64'd0);
        check("reset pending", 64'(Pending), 64'd0);
        check("reset waitcnt", 64'(WaitCnt), 64'd0);
        HRESETn = 1'b1;

        for (int i = 0; i < 19; i++) begin
            @(negedge HCLK);
            drive(vecs[i].hsel, vecs[i].htrans, vecs[i].grant, vecs[i].grantd,
                  vecs[i].hreadys, vecs[i].hresps, vecs[i].hrdatas);
            #2;
            check($sformatf("v%0d hreadym", i), 64'(HREADYM), 64'(vecs[i].e_hready));
            check($sformatf("v%0d hrespm", i),  64'(HRESPM),  64'(vecs[i].e_hresp));
            check($sformatf("v%0d hrdatam", i), HRDATAM,      vecs[i].e_hrdata);
            check($sformatf("v%0d pending", i), 64'(Pending), 64'(vecs[i].e_pending));
            check($sformatf("v%0d waitcnt", i), 64'(WaitCnt), 64'(vecs[i].e_wait));
        end

        // Two-cycle ERROR response: hold register keeps 0x99.
        @(negedge HCLK); drive(1, T_NS, 1, 0, 1, 0, 64'h0); #2;
        check("err c0 hreadym", 64'(HREADYM), 64'd1);
        @(negedge HCLK); drive(0, T_ID, 0, 1, 0, 1, 64'hBAD); #2;
        check("err c1 hreadym", 64'(HREADYM), 64'd0);
        check("err c1 hrespm",  64'(HRESPM),  64'd1);
        @(negedge HCLK); drive(0, T_ID, 0, 1, 1, 1, 64'hBAD2); #2;
        check("err c2 hreadym", 64'(HREADYM), 64'd1);
        check("err c2 hrespm",  64'(HRESPM),  64'd1);
        @(negedge HCLK); drive(0, T_ID, 0, 0, 1, 0, 64'h5); #2;
        check("err after hrdatam", HRDATAM,      64'h99);
        check("err after hrespm",  64'(HRESPM),  64'd0);
        check("err after pending", 64'(Pending), 64'd0);

        // Asynchronous reset while in HOLD.
        @(negedge HCLK); drive(1, T_NS, 0, 0, 1, 0, 64'h0);
        @(negedge HCLK);
        @(negedge HCLK); #2;
        check("rst hold pre pending", 64'(Pending), 64'd1);
        check("rst hold pre waitcnt", 64'(WaitCnt), 64'd1);
        HRESETn = 1'b0; #1;
        check("rst hold hreadym", 64'(HREADYM), 64'd1);
        check("rst hold hrespm",  64'(HRESPM),  64'd0);
        check("rst hold pending", 64'(Pending), 64'd0);
        check("rst hold waitcnt", 64'(WaitCnt), 64'd0);
        check("rst hold hrdatam", HRDATAM,      64'd0);
        drive(0, T_ID, 0, 0, 1, 0, 64'h0);
        @(negedge HCLK); HRESETn = 1'b1;

        // Asynchronous reset while in ERR, after a completed read loaded the hold register.
        @(negedge HCLK); drive(1, T_NS, 1, 0, 1, 0, 64'h0);
        @(negedge HCLK); drive(1, T_SQ, 1, 1, 1, 0, 64'hCAFE);
        @(negedge HCLK); drive(0, T_ID, 0, 1, 0, 1, 64'hBEEF);
        @(negedge HCLK); drive(0, T_ID, 0, 1, 0, 1, 64'hBEEF); #2;
        check("rst err pre hrespm",  64'(HRESPM),  64'd1);
        check("rst err pre hreadym", 64'(HREADYM), 64'd0);
        HRESETn = 1'b0; #1;
        check("rst err hreadym", 64'(HREADYM), 64'd1);
        check("rst err hrespm",  64'(HRESPM),  64'd0);
        check("rst err hrdatam", HRDATAM,      64'd0);
        check("rst err waitcnt", 64'(WaitCnt), 64'd0);
        drive(0, T_ID, 0, 0, 1, 0, 64'h0);
        @(negedge HCLK); HRESETn = 1'b1;

        // Six HOLD cycles: the 2-bit counter saturates at 3, the 8-bit one reaches 6.
        @(negedge HCLK); drive(1, T_NS, 0, 0, 1, 0, 64'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge HCLK); drive(1, T_NS, (k == 5), 0, 1, 0, 64'h0); #2;
            if (k == 4) check("sat mid waitcnt2", 64'(waitcnt2), 64'd3);
        end
        @(negedge HCLK); drive(0, T_ID, 0, 1, 1, 0, 64'h1234); #2;
        check("sat waitcnt2",  64'(waitcnt2), 64'd3);
        check("sat waitcnt",   64'(WaitCnt),  64'd6);
        check("sat pending",   64'(Pending),  64'd0);
        check("sat hrdatam2",  hrdatam2,      64'h1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
